expr_fsm_p: RTL and testbench

EXPR_FSM_P -- requirements
Module: expr_fsm_p

---
 rtl/expr_fsm_p.sv | 113 +++++++++++
 tb/tb_expr_fsm_p.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/expr_fsm_p.sv
// Streaming recogniser for infix integer expressions with parentheses,
// fed one ASCII byte per valid cycle; flags legality, errors and '=' completion.
module expr_fsm_p #(
  parameter int         DEPTH      = 7,
  parameter int         MAX_DIGITS = 8,
  parameter logic [3:0] OP_MASK    = 4'b0011
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [7:0]                 in,
  input  logic                       in_valid,
  output logic                       out,
  output logic                       err,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(MAX_DIGITS);

  typedef enum logic [1:0] {
    OPND  = 2'd0,
    NUM   = 2'd1,
    CLOSE = 2'd2,
    ILL   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] depth_n;
  logic [CW-1:0] count, count_n;
  logic          out_n, done_n;
  logic          consume, is_digit, is_op;

  always_comb begin
    consume  = in_valid && (in != 8'h20);
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_op    = ((in == 8'h2B) && OP_MASK[0]) ||
               ((in == 8'h2A) && OP_MASK[1]) ||
               ((in == 8'h2D) && OP_MASK[2]) ||
               ((in == 8'h2F) && OP_MASK[3]);
  end

  always_comb begin
    state_n = state;
    depth_n = depth;
    count_n = count;
    done_n  = 1'b0;
    case (state)
      OPND: begin
        if (consume) begin
          if (is_digit) begin
            state_n = NUM;
            count_n = CW'(1);
          end else if ((in == 8'h28) && (depth < DMAX)) begin
            depth_n = depth + DW'(1);
          end else begin
            state_n = ILL;
          end
        end
      end
      // NUM and CLOSE differ only in whether another digit may follow
      NUM, CLOSE: begin
        if (consume) begin
          if (is_digit && (state == NUM) && (count < CMAX)) begin
            count_n = count + CW'(1);
          end else if (is_op) begin
            state_n = OPND;
            count_n = '0;
          end else if ((in == 8'h29) && (depth != '0)) begin
            state_n = CLOSE;
            depth_n = depth - DW'(1);
          end else if ((in == 8'h3D) && (depth == '0)) begin
            state_n = OPND;
            count_n = '0;
            done_n  = 1'b1;
          end else begin
            state_n = ILL;
          end
        end
      end
      ILL: begin
        state_n = ILL;
      end
      default: begin
        state_n = OPND;
        depth_n = '0;
        count_n = '0;
      end
    endcase
    out_n = ((state_n == NUM) || (state_n == CLOSE)) && (depth_n == '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= OPND;
      depth <= '0;
      count <= '0;
      out   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      depth <= depth_n;
      count <= count_n;
      out   <= out_n;
      done  <= done_n;
    end
  end

  assign err = (state == ILL);

endmodule

// File: tb/tb_expr_fsm_p.sv
// Bench for expr_fsm_p: one default instance and one narrow instance
// (DEPTH=2, MAX_DIGITS=3, all operators), driven from a vector table.
module tb_expr_fsm_p;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] inA, inB;
  logic       vA, vB;
  logic       outA, errA, doneA;
  logic [2:0] depthA;
  logic       outB, errB, doneB;
  logic [1:0] depthB;

  always #5 clk = ~clk;

  expr_fsm_p dutA (
    .clk(clk), .clr(clr), .in(inA), .in_valid(vA),
    .out(outA), .err(errA), .done(doneA), .depth(depthA)
  );

  expr_fsm_p #(.DEPTH(2), .MAX_DIGITS(3), .OP_MASK(4'b1111)) dutB (
    .clk(clk), .clr(clr), .in(inB), .in_valid(vB),
    .out(outB), .err(errB), .done(doneB), .depth(depthB)
  );

  typedef struct {
    bit         sel;
    bit         isClr;
    logic [7:0] ch;
    logic       vld;
    logic       eo, ee, ed;
    int         edep;
  } vec_t;

  typedef struct {
    bit   sel;
    int   idx;
    logic eo, ee, ed;
    int   edep;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void addVec(input bit sel, input logic [7:0] ch, input logic vld,
                                 input logic eo, input logic ee, input logic ed,
                                 input int edep);
    vec_t v;
    v.sel = sel; v.isClr = 1'b0; v.ch = ch; v.vld = vld;
    v.eo = eo; v.ee = ee; v.ed = ed; v.edep = edep;
    vecs.push_back(v);
  endfunction

  function automatic void addClr();
    vec_t v;
    v.sel = 1'b0; v.isClr = 1'b1; v.ch = 8'h00; v.vld = 1'b0;
    v.eo = 1'b0; v.ee = 1'b0; v.ed = 1'b0; v.edep = 0;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput();
    exp_t e;
    logic ao, ae, ad;
    int   adep;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard empty: got an output with no expectation queued");
    end else begin
      e = sb.pop_front();
      ao   = e.sel ? outB  : outA;
      ae   = e.sel ? errB  : errA;
      ad   = e.sel ? doneB : doneA;
      adep = e.sel ? int'(depthB) : int'(depthA);
      if (ao !== e.eo || ae !== e.ee || ad !== e.ed || adep != e.edep) begin
        fails++;
        $display("[TB] FAIL vec%0d dut%s out/err/done/depth got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 e.idx, e.sel ? "B" : "A", ao, ae, ad, adep, e.eo, e.ee, e.ed, e.edep);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    vA = 1'b0;
    vB = 1'b0;
    if (v.sel) begin
      inB = v.ch; vB = v.vld;
    end else begin
      inA = v.ch; vA = v.vld;
    end
    e.sel = v.sel; e.idx = idx; e.eo = v.eo; e.ee = v.ee; e.ed = v.ed; e.edep = v.edep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkZero(input string name);
    tests++;
    if ({outA, errA, doneA, depthA, outB, errB, doneB, depthB} !== '0) begin
      fails++;
      $display("[TB] FAIL %s A o/e/d/dep=%b/%b/%b/%0d B o/e/d/dep=%b/%b/%b/%0d want all 0",
               name, outA, errA, doneA, depthA, outB, errB, doneB, depthB);
    end
  endtask

  // clr raised mid-cycle: outputs must drop before the next clock edge
  task automatic doClear(input int idx);
    @(negedge clk);
    vA = 1'b0;
    vB = 1'b0;
    #1 clr = 1'b1;
    #1 checkZero($sformatf("clear%0d", idx));
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    vec_t v;
    clr = 1'b1; vA = 1'b0; vB = 1'b0; inA = 8'h00; inB = 8'h00;

    // "12+3*4=" with valid gaps
    addVec(0, "1", 1, 1,0,0,0);  addVec(0, 8'h00, 0, 1,0,0,0);
    addVec(0, "2", 1, 1,0,0,0);  addVec(0, "+", 1, 0,0,0,0);
    addVec(0, 8'h00, 0, 0,0,0,0); addVec(0, "3", 1, 1,0,0,0);
    addVec(0, "*", 1, 0,0,0,0);  addVec(0, "4", 1, 1,0,0,0);
    addVec(0, "=", 1, 0,0,1,0);  addVec(0, 8'h00, 0, 0,0,0,0);
    // "((7))="
    addVec(0, "(", 1, 0,0,0,1);  addVec(0, "(", 1, 0,0,0,2);
    addVec(0, "7", 1, 0,0,0,2);  addVec(0, ")", 1, 0,0,0,1);
    addVec(0, ")", 1, 1,0,0,0);  addVec(0, "=", 1, 0,0,1,0);
    addVec(0, 8'h00, 0, 0,0,0,0);
    // "3 + 4 " then ')' at depth 0, error is sticky
    addVec(0, "3", 1, 1,0,0,0);  addVec(0, " ", 1, 1,0,0,0);
    addVec(0, "+", 1, 0,0,0,0);  addVec(0, " ", 1, 0,0,0,0);
    addVec(0, "4", 1, 1,0,0,0);  addVec(0, " ", 1, 1,0,0,0);
    addVec(0, ")", 1, 0,1,0,0);  addVec(0, "1", 1, 0,1,0,0);
    addClr();
    // '-' disabled by default
    addVec(0, "5", 1, 1,0,0,0);  addVec(0, "-", 1, 0,1,0,0);
    addVec(0, "2", 1, 0,1,0,0);
    addClr();
    // "(3=" : '=' with open paren, depth frozen
    addVec(0, "(", 1, 0,0,0,1);  addVec(0, "3", 1, 0,0,0,1);
    addVec(0, "=", 1, 0,1,0,1);  addVec(0, 8'h00, 0, 0,1,0,1);
    addClr();
    addVec(0, "=", 1, 0,1,0,0);
    addClr();
    // narrow instance: nesting overflow
    addVec(1, "(", 1, 0,0,0,1);  addVec(1, "(", 1, 0,0,0,2);
    addVec(1, "(", 1, 0,1,0,2);  addVec(1, "5", 1, 0,1,0,2);
    addVec(1, ")", 1, 0,1,0,2);
    addClr();
    // digit limit
    addVec(1, "1", 1, 1,0,0,0);  addVec(1, "2", 1, 1,0,0,0);
    addVec(1, "3", 1, 1,0,0,0);  addVec(1, "4", 1, 0,1,0,0);
    addClr();
    // all operators enabled
    addVec(1, "5", 1, 1,0,0,0);  addVec(1, "-", 1, 0,0,0,0);
    addVec(1, "2", 1, 1,0,0,0);  addVec(1, "/", 1, 0,0,0,0);
    addVec(1, "8", 1, 1,0,0,0);  addVec(1, "=", 1, 0,0,1,0);
    addVec(1, 8'h00, 0, 0,0,0,0);

    #1 checkZero("reset");
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.isClr) doClear(i);
      else applyStimulus(v, i);
    end

    // clr coinciding with a clock edge that carries a byte
    @(negedge clk);
    inA = "5"; vA = 1'b1; vB = 1'b0;
    @(posedge clk);
    clr = 1'b1;
    #1 checkZero("clrOnEdge");
    @(negedge clk);
    clr = 1'b0; vA = 1'b0;
    @(posedge clk);
    #1 checkZero("afterClrEdge");
    // new expression starts in OPND, so a leading operator is illegal
    v.sel = 1'b0; v.isClr = 1'b0; v.ch = "+"; v.vld = 1'b1;
    v.eo = 1'b0; v.ee = 1'b1; v.ed = 1'b0; v.edep = 0;
    applyStimulus(v, 999);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
